// File: rtl/feeder_schedule_timer.sv
// Feed-interval countdown and hopper portion tracker for the pet feeder.
// Requests one dispense per feed over a req/done handshake to the motor stage.
module feeder_schedule_timer #(
    parameter int         CLK_HZ_DIV   = 50000000,
    parameter logic [7:0] FEED_H       = 8'd4,
    parameter logic [7:0] FEED_M       = 8'd0,
    parameter logic [7:0] FEED_S       = 8'd0,
    parameter logic [7:0] MAX_PORTIONS = 8'd12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       feed_now,
    input  logic       refill,
    input  logic       feed_done,
    output logic       feed_req,
    output logic       ready_o,
    output logic [7:0] time_hours,
    output logic [7:0] time_minutes,
    output logic [7:0] time_seconds,
    output logic [7:0] porciones,
    output logic       empty
);

    localparam int PW = (CLK_HZ_DIV > 1) ? $clog2(CLK_HZ_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ_DIV - 1);

    localparam logic [1:0] ST_COUNTING = 2'd0;
    localparam logic [1:0] ST_FEED_REQ = 2'd1;
    localparam logic [1:0] ST_EMPTY    = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    h_q, h_d, m_q, m_d, s_q, s_d;
    logic [7:0]    porc_q, porc_d;
    logic          req_q, req_d;
    logic          empty_q, empty_d;
    logic          ready_q;
    logic          tick;

    assign tick  = (pre_q == PRE_MAX);
    assign pre_d = tick ? '0 : pre_q + PW'(1);

    // Decisions use the portion count held at the start of the cycle; a
    // coincident refill only updates the stored count.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        m_d     = m_q;
        s_d     = s_q;
        porc_d  = porc_q;
        req_d   = req_q;
        empty_d = empty_q;
        case (state_q)
            ST_COUNTING: begin
                if (feed_now && porc_q != 8'd0) begin
                    h_d     = FEED_H;
                    m_d     = FEED_M;
                    s_d     = FEED_S;
                    state_d = ST_FEED_REQ;
                    req_d   = 1'b1;
                end else if (tick) begin
                    if (s_q != 8'd0) begin
                        s_d = s_q - 8'd1;
                    end else if (m_q != 8'd0) begin
                        m_d = m_q - 8'd1;
                        s_d = 8'd59;
                    end else if (h_q != 8'd0) begin
                        h_d = h_q - 8'd1;
                        m_d = 8'd59;
                        s_d = 8'd59;
                    end else if (porc_q != 8'd0) begin
                        h_d     = FEED_H;
                        m_d     = FEED_M;
                        s_d     = FEED_S;
                        state_d = ST_FEED_REQ;
                        req_d   = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                        empty_d = 1'b1;
                    end
                end
                if (refill) begin
                    porc_d = MAX_PORTIONS;
                end
            end
            ST_FEED_REQ: begin
                if (feed_done) begin
                    state_d = ST_COUNTING;
                    req_d   = 1'b0;
                    porc_d  = refill ? MAX_PORTIONS : porc_q - 8'd1;
                end else if (refill) begin
                    porc_d = MAX_PORTIONS;
                end
            end
            ST_EMPTY: begin
                if (refill) begin
                    porc_d  = MAX_PORTIONS;
                    h_d     = FEED_H;
                    m_d     = FEED_M;
                    s_d     = FEED_S;
                    state_d = ST_COUNTING;
                    empty_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_COUNTING;
                req_d   = 1'b0;
                empty_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_COUNTING;
            pre_q   <= '0;
            h_q     <= FEED_H;
            m_q     <= FEED_M;
            s_q     <= FEED_S;
            porc_q  <= MAX_PORTIONS;
            req_q   <= 1'b0;
            empty_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            h_q     <= h_d;
            m_q     <= m_d;
            s_q     <= s_d;
            porc_q  <= porc_d;
            req_q   <= req_d;
            empty_q <= empty_d;
            ready_q <= 1'b1;
        end
    end

    assign feed_req     = req_q;
    assign ready_o      = ready_q;
    assign time_hours   = h_q;
    assign time_minutes = m_q;
    assign time_seconds = s_q;
    assign porciones    = porc_q;
    assign empty        = empty_q;

endmodule

// File: tb/tb_feeder_schedule_timer.sv
// Bench for feeder_schedule_timer: a seconds-remaining reference model is
// stepped alongside the DUT and compared on every falling clock edge.
module tb_feeder_schedule_timer;

    localparam int         DIV     = 2;
    localparam logic [7:0] FH      = 8'd1;
    localparam logic [7:0] FM      = 8'd0;
    localparam logic [7:0] FS      = 8'd2;
    localparam logic [7:0] MAXP    = 8'd2;
    localparam int         INTERVAL = 3600 * FH + 60 * FM + FS;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       feedNow = 1'b0;
    logic       refill = 1'b0;
    logic       feedDone = 1'b0;
    logic       feedReq;
    logic       readyO;
    logic [7:0] timeHours, timeMinutes, timeSeconds, porciones;
    logic       emptyO;

    int compared = 0;
    int mismatched = 0;

    // Reference model: remaining seconds, mode 0=counting 1=requesting 2=empty
    int mRem, mMode, mPorc, mPre, mReady;
    int reqCycles = 0;

    feeder_schedule_timer #(
        .CLK_HZ_DIV(DIV), .FEED_H(FH), .FEED_M(FM), .FEED_S(FS), .MAX_PORTIONS(MAXP)
    ) dut (
        .clk(clk), .reset(reset), .feed_now(feedNow), .refill(refill),
        .feed_done(feedDone), .feed_req(feedReq), .ready_o(readyO),
        .time_hours(timeHours), .time_minutes(timeMinutes),
        .time_seconds(timeSeconds), .porciones(porciones), .empty(emptyO)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mRem = INTERVAL; mMode = 0; mPorc = MAXP; mPre = 0; mReady = 0;
    endtask

    task automatic modelStep(input bit fn, input bit rf, input bit fd);
        bit tick;
        tick = (mPre == DIV - 1);
        mPre = (mPre + 1) % DIV;
        mReady = 1;
        case (mMode)
            0: begin
                if (fn && mPorc != 0) begin
                    mRem = INTERVAL; mMode = 1;
                end else if (tick) begin
                    if (mRem > 0) mRem = mRem - 1;
                    else if (mPorc != 0) begin mRem = INTERVAL; mMode = 1; end
                    else mMode = 2;
                end
                if (rf) mPorc = MAXP;
            end
            1: begin
                if (fd) begin
                    mPorc = rf ? int'(MAXP) : mPorc - 1;
                    mMode = 0;
                end else if (rf) mPorc = MAXP;
            end
            default: begin
                if (rf) begin mPorc = MAXP; mRem = INTERVAL; mMode = 0; end
            end
        endcase
    endtask

    task automatic checkField(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkField("hours",    timeHours,   mRem / 3600);
        checkField("minutes",  timeMinutes, (mRem / 60) % 60);
        checkField("seconds",  timeSeconds, mRem % 60);
        checkField("portions", porciones,   mPorc);
        checkField("feedReq",  feedReq,     (mMode == 1) ? 1 : 0);
        checkField("empty",    emptyO,      (mMode == 2) ? 1 : 0);
        checkField("ready",    readyO,      mReady);
    endtask

    // Called at a falling edge: drive inputs, advance model, compare at next falling edge.
    task automatic applyStimulus(input bit fn, input bit rf, input bit fd);
        feedNow = fn; refill = rf; feedDone = fd;
        modelStep(fn, rf, fd);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic autoDone(output bit fd);
        if (mMode == 1) reqCycles++;
        else reqCycles = 0;
        fd = (mMode == 1 && reqCycles == 5);
    endtask

    initial begin
        bit fd;
        int n;
        modelReset();
        #12;
        checkOutput();
        checkField("resetReady", readyO, 0);
        checkField("resetHours", timeHours, 1);
        checkField("resetSeconds", timeSeconds, 2);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, 0, 0);
        checkField("readyFirstEdge", readyO, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0);
        checkField("edge4Hours", timeHours, 1);
        checkField("edge4Seconds", timeSeconds, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0);
        checkField("edge6Hours", timeHours, 0);
        checkField("edge6Minutes", timeMinutes, 59);
        checkField("edge6Seconds", timeSeconds, 59);

        // Natural countdown to empty with stray feed_done pulses outside requests
        n = 0;
        while (mMode != 2 && n < 25000) begin
            autoDone(fd);
            if (mMode != 1 && $urandom_range(29) == 0) fd = 1'b1;
            applyStimulus(0, 0, fd);
            n++;
        end
        checkField("reachEmpty", emptyO, 1);
        checkField("emptyPortions", porciones, 0);
        checkField("emptySeconds", timeSeconds, 0);

        for (int i = 0; i < 40; i++) applyStimulus($urandom_range(3) == 0, 0, 0);
        checkField("emptyHoldsReq", feedReq, 0);
        checkField("emptyHolds", emptyO, 1);

        applyStimulus(0, 1, 0);
        checkField("refillPortions", porciones, 2);
        checkField("refillEmpty", emptyO, 0);
        checkField("refillHours", timeHours, 1);
        checkField("refillSeconds", timeSeconds, 2);

        // feed_now coincident with a tick
        n = 0;
        while (!(mMode == 0 && mPre == DIV - 1 && mPorc != 0) && n < 50) begin
            applyStimulus(0, mMode == 2 || mPorc == 0, mMode == 1);
            n++;
        end
        applyStimulus(1, 0, 0);
        checkField("feedNowTickReq", feedReq, 1);
        checkField("feedNowTickSeconds", timeSeconds, 2);
        applyStimulus(0, 1, 1);
        checkField("doneRefillPortions", porciones, 2);
        checkField("doneRefillReq", feedReq, 0);

        // Randomized traffic
        for (int i = 0; i < 12000; i++) begin
            if (mMode == 1) fd = ($urandom_range(3) == 0);
            else fd = ($urandom_range(19) == 0);
            applyStimulus($urandom_range(39) == 0, $urandom_range(149) == 0, fd);
        end

        // Asynchronous reset while a request is outstanding
        n = 0;
        while (mMode != 1 && n < 20) begin
            applyStimulus(mMode == 0 && mPorc != 0, mMode == 2 || mPorc == 0, 0);
            n++;
        end
        checkField("reqBeforeReset", feedReq, 1);
        feedNow = 0; refill = 0; feedDone = 0;
        #2 reset = 1'b0;
        #1;
        checkField("asyncReqDrop", feedReq, 0);
        checkField("asyncReadyDrop", readyO, 0);
        modelReset();
        checkOutput();
        @(negedge clk);
        checkOutput();
        reset = 1'b1;
        for (int i = 0; i < 300; i++) applyStimulus($urandom_range(19) == 0, 0, $urandom_range(3) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
